// File: rtl/byte_serial_add_seq_pkg.sv
// byte_serial_add_seq_pkg: shared byte width and FSM encodings for the byte-serial add sequencer
package byte_serial_add_seq_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/byte_serial_add_seq.sv
// byte_serial_add_seq: wide add performed one byte per cycle on an external 8-bit adder slice
// Define BYTE_SERIAL_ADD_SUB_EN to add the in_sub port (A - B via ~B and forced carry-in).
module byte_serial_add_seq
    import byte_serial_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
`ifdef BYTE_SERIAL_ADD_SUB_EN
    input  logic                     in_sub,
`endif
    output logic [BYTE_W-1:0]        add_a,
    output logic [BYTE_W-1:0]        add_b,
    output logic                     add_cin,
    input  logic [BYTE_W-1:0]        add_sum,
    input  logic                     add_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     c_out
);
    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = $clog2(NBYTES);

    state_t        state, state_n;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q, b_q;
    logic          carry, sub_q, cin0, accept, run, last;

`ifdef BYTE_SERIAL_ADD_SUB_EN
    // Subtraction is A + ~B + 1, so the first carry is forced high.
    assign cin0 = in_sub | in_cin;
    always_ff @(posedge clk or posedge rst)
        if (rst) sub_q <= 1'b0;
        else if (accept) sub_q <= in_sub;
`else
    assign cin0  = in_cin;
    assign sub_q = 1'b0;
`endif

    assign run       = state == ST_RUN;
    assign accept    = state == ST_IDLE && in_valid;
    assign last      = idx == IW'(NBYTES - 1);
    assign in_ready  = state == ST_IDLE && !rst;
    assign out_valid = state == ST_DONE;
    assign add_a     = run ? a_q[BYTE_W*idx +: BYTE_W] : '0;
    assign add_b     = run ? b_q[BYTE_W*idx +: BYTE_W] ^ {BYTE_W{sub_q}} : '0;
    assign add_cin   = run ? carry : 1'b0;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        if (accept) state_n = ST_RUN;
        if (run && last) state_n = ST_DONE;
        if (state == ST_DONE && out_ready) state_n = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            a_q   <= in_a;
            b_q   <= in_b;
            carry <= cin0;
            sum   <= '0;
        end else if (run) begin
            sum[BYTE_W*idx +: BYTE_W] <= add_sum;
            carry <= add_cout;
            idx   <= idx + 1'b1;
            if (last) c_out <= add_cout;
        end
endmodule

// File: tb/tb_byte_serial_add_seq.sv
// tb_byte_serial_add_seq: scoreboard bench for byte_serial_add_seq with a real 8-bit slice model
module tb_byte_serial_add_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, in_cin = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, sum;
    logic [7:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout, out_valid, out_ready = 1'b0, c_out;
`ifdef BYTE_SERIAL_ADD_SUB_EN
    logic         in_sub = 1'b0;
`endif
    int checks = 0, errors = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    byte_serial_add_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef BYTE_SERIAL_ADD_SUB_EN
        .in_sub(in_sub),
`endif
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out)
    );

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every result handshake pops and compares the oldest expected result.
    always @(negedge clk)
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h expected none", {c_out, sum});
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                if ({c_out, sum} !== e) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", {c_out, sum}, e);
                end
            end
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec);
        int n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        sb.push_back({ec, es});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_idle_reset(input string name);
        chk({name, "_out_valid"}, W'(out_valid), 0);
        chk({name, "_sum"}, {c_out, sum}, 0);
        chk({name, "_add"}, {add_cin, add_a, add_b}, 0);
    endtask

    initial begin
        int n;
        in_a = 32'hCAFE_F00D; in_b = 32'h1234_5678;
        #2;
        chk_idle_reset("reset");
        chk("reset_in_ready", W'(in_ready), 0);
        tick(); rst = 1'b0; #1;
        chk("in_ready_after_reset", W'(in_ready), 1);

        // 1: latency is exactly NB edges after accept
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
        repeat (NB - 1) tick();
        chk("latency_early", W'(out_valid), 0);
        tick();
        chk("latency_exact", W'(out_valid), 1);
        drain();
        chk("idle_after_drain", W'({out_valid, in_ready}), 1);

        // 2: carry ripples through every byte
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        wait_done(); drain();

        // 3: DONE holds under backpressure and ignores new operands
        send(32'h0102_0304, 32'h1020_3040, 1'b0, 32'h1122_3344, 1'b0);
        wait_done();
        in_a = 32'h5555_5555; in_b = 32'h2222_2222; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_sum", {c_out, sum}, {1'b0, 32'h1122_3344});
            chk("hold_flags", W'({in_ready, out_valid}), 1);
        end
        in_valid = 1'b0;
        drain();

        // 4: reset mid-op drops the op
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0);
        tick(); tick();
        rst = 1'b1; #1;
        sb.delete();
        chk_idle_reset("midrun_reset");
        tick(); rst = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
        wait_done(); drain();

        // 5: back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        sb.push_back({1'b1, 32'h0101_0100});
        in_a = 32'h8080_8080; in_b = 32'h8080_8080; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_a = 32'hDEAD_BEEF; in_b = 32'h0101_0101; in_cin = 1'b1;
        sb.push_back({1'b0, 32'hDFAE_BFF1});
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_gap", W'(n), W'(NB + 1));
        tick();
        chk("b2b_accept", W'(in_ready), 0);
        in_valid = 1'b0;
        wait_done();
        tick();
        out_ready = 1'b0;

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
        wait_done(); drain();

`ifdef BYTE_SERIAL_ADD_SUB_EN
        // 6: subtraction, c_out is NOT-borrow; in_cin ignored
        in_sub = 1'b1;
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0);
        wait_done(); drain();
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1);
        wait_done(); drain();
        in_sub = 1'b0;
`endif

        tick();
        chk("scoreboard_empty", W'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
